// File: rtl/feedback_receiver_pkg.sv
// Shared constants for the feedback receive path: FSM encodings, channel code, baud divider.
package feedback_receiver_pkg;

  typedef logic [7:0] uart_byte_t;

  // Receiver FSM encodings, kept as plain constants for legacy tools.
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  // Channel code in byte bits [1:0] that marks a feedback byte.
  localparam logic [1:0] ChannelFeedback = 2'b01;

  // Clock cycles per oversample tick, truncated; never below one.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned oversample);
    int unsigned div;
    div = clk_freq / (baud * oversample);
    return (div == 0) ? 1 : div;
  endfunction

endpackage

// File: rtl/feedback_receiver_if.sv
// Serial line plus receive-side results, as seen by the game link and the script engine.
interface feedback_receiver_if;
  import feedback_receiver_pkg::*;

  logic       rx;
  uart_byte_t rx_byte;
  logic       rx_valid;
  uart_byte_t feedback;
  logic       feedback_update;
  logic       frame_error;
  logic       feedback_stale;

  // Receiver side.
  modport slave (
    input  rx,
    output rx_byte, rx_valid, feedback, feedback_update, frame_error, feedback_stale
  );

  // Line driver / consumer side.
  modport master (
    output rx,
    input  rx_byte, rx_valid, feedback, feedback_update, frame_error, feedback_stale
  );
endinterface

// File: rtl/feedback_receiver_uart_rx_core.sv
// 8N1 UART deserialiser: rx synchroniser, oversample tick generator and bit-level FSM.
// byte_valid / frame_error are single-cycle pulses in the stop-sample cycle.
module feedback_receiver_uart_rx_core
  import feedback_receiver_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output uart_byte_t byte_data,
  output logic       byte_valid,
  output logic       frame_error
);

  localparam int unsigned Div   = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned TickW = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned SampW = $clog2(OVERSAMPLE + 1);

  logic             rx_meta_q, rx_s_q;
  logic [1:0]       state_q, state_d;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic [SampW-1:0] samp_q, samp_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  uart_byte_t       shift_q, shift_d;
  logic             armed_q, armed_d;
  logic             tick;
  logic             samp_last, samp_half;

  assign tick      = (state_q != StIdle) && (tick_cnt_q == TickW'(Div - 1));
  assign samp_last = (samp_q == SampW'(OVERSAMPLE - 1));
  assign samp_half = (samp_q == SampW'(OVERSAMPLE / 2 - 1));

  // Tick counter free-runs outside IDLE and is pinned to zero inside it.
  always_comb begin
    tick_cnt_d = tick_cnt_q + TickW'(1);
    if (state_q == StIdle || tick) begin
      tick_cnt_d = '0;
    end
  end

  // Bit-level receive FSM; armed blocks re-triggering until the line has been seen high.
  always_comb begin
    state_d     = state_q;
    samp_d      = samp_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    armed_d     = armed_q;
    byte_valid  = 1'b0;
    frame_error = 1'b0;
    case (state_q)
      StIdle: begin
        if (rx_s_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = StStart;
          samp_d  = '0;
        end
      end
      StStart: begin
        if (tick) begin
          if (samp_half) begin
            if (rx_s_q) begin
              state_d = StIdle;
            end else begin
              state_d   = StData;
              bit_idx_d = 3'd0;
              samp_d    = '0;
            end
          end else begin
            samp_d = samp_q + SampW'(1);
          end
        end
      end
      StData: begin
        if (tick) begin
          if (samp_last) begin
            shift_d[bit_idx_q] = rx_s_q;
            samp_d             = '0;
            if (bit_idx_q == 3'd7) begin
              state_d = StStop;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end else begin
            samp_d = samp_q + SampW'(1);
          end
        end
      end
      StStop: begin
        if (tick) begin
          if (samp_last) begin
            state_d     = StIdle;
            armed_d     = rx_s_q;
            byte_valid  = rx_s_q;
            frame_error = ~rx_s_q;
          end else begin
            samp_d = samp_q + SampW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Synchroniser and FSM state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      samp_q     <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= '0;
      armed_q    <= 1'b1;
    end else begin
      rx_meta_q  <= rx;
      rx_s_q     <= rx_meta_q;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      samp_q     <= samp_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      armed_q    <= armed_d;
    end
  end

  assign byte_data = shift_q;

endmodule

// File: rtl/feedback_receiver.sv
// Feedback receive path: UART core plus feedback-channel filter, hold register and
// staleness tracking.
module feedback_receiver
  import feedback_receiver_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 100_000_000,
  parameter int unsigned BAUD         = 9600,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned STALE_CYCLES = 50_000_000
) (
  input logic                 clk,
  input logic                 rst,
  feedback_receiver_if.slave  bus
);

  localparam int unsigned StaleW = $clog2(STALE_CYCLES + 1);

  uart_byte_t        core_byte;
  logic              core_valid, core_ferr;
  logic              fb_hit;

  uart_byte_t        rx_byte_q, feedback_q;
  logic              rx_valid_q, fb_update_q, frame_error_q;
  logic [StaleW-1:0] stale_cnt_q, stale_cnt_d;
  logic              stale_q, stale_d;

  feedback_receiver_uart_rx_core #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_rx_core (
    .clk         (clk),
    .rst         (rst),
    .rx          (bus.rx),
    .byte_data   (core_byte),
    .byte_valid  (core_valid),
    .frame_error (core_ferr)
  );

  assign fb_hit = core_valid && (core_byte[1:0] == ChannelFeedback);

  // Stale counter restarts with each feedback byte and saturates rather than wrapping.
  always_comb begin
    stale_cnt_d = stale_cnt_q;
    stale_d     = stale_q;
    if (fb_hit) begin
      stale_cnt_d = '0;
      stale_d     = 1'b0;
    end else if (stale_cnt_q != StaleW'(STALE_CYCLES)) begin
      stale_cnt_d = stale_cnt_q + StaleW'(1);
      if (stale_cnt_d == StaleW'(STALE_CYCLES)) begin
        stale_d = 1'b1;
      end
    end
  end

  // Output registers; strobes land in the cycle after the stop sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_byte_q     <= '0;
      rx_valid_q    <= 1'b0;
      feedback_q    <= '0;
      fb_update_q   <= 1'b0;
      frame_error_q <= 1'b0;
      stale_cnt_q   <= '0;
      stale_q       <= 1'b1;
    end else begin
      rx_valid_q    <= core_valid;
      fb_update_q   <= fb_hit;
      frame_error_q <= core_ferr;
      stale_cnt_q   <= stale_cnt_d;
      stale_q       <= stale_d;
      if (core_valid) begin
        rx_byte_q <= core_byte;
      end
      if (fb_hit) begin
        feedback_q <= core_byte;
      end
    end
  end

  assign bus.rx_byte         = rx_byte_q;
  assign bus.rx_valid        = rx_valid_q;
  assign bus.feedback        = feedback_q;
  assign bus.feedback_update = fb_update_q;
  assign bus.frame_error     = frame_error_q;
  assign bus.feedback_stale  = stale_q;

endmodule

// File: tb/tb_feedback_receiver.sv
// Directed bench for feedback_receiver: channel filtering, framing errors, glitches,
// mid-frame reset and staleness timing.
module tb_feedback_receiver;

  // 1.536 MHz / (9600 * 16) = 10 cycles per tick, 160 cycles per bit.
  localparam int unsigned ClkFreq   = 1_536_000;
  localparam int unsigned Baud      = 9600;
  localparam int unsigned Os        = 16;
  localparam int unsigned Stale     = 1000;
  localparam int          BitCycles = 160;

  logic clk = 1'b0;
  logic rst = 1'b1;

  feedback_receiver_if bus ();

  feedback_receiver #(
    .CLK_FREQ     (ClkFreq),
    .BAUD         (Baud),
    .OVERSAMPLE   (Os),
    .STALE_CYCLES (Stale)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Monitor state, sampled on the falling edge.
  int   cyc = 0;
  int   n_valid = 0, n_upd = 0, n_fe = 0;
  int   n_wide = 0, n_mis = 0;
  int   upd_cyc = 0, rise_cyc = 0;
  logic stale_at_upd = 1'b1;
  logic prev_valid = 1'b0, prev_upd = 1'b0, prev_fe = 1'b0, prev_stale = 1'b1;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.rx_valid) n_valid = n_valid + 1;
    if (bus.frame_error) n_fe = n_fe + 1;
    if (bus.feedback_update) begin
      n_upd        = n_upd + 1;
      upd_cyc      = cyc;
      stale_at_upd = bus.feedback_stale;
      if (!bus.rx_valid) n_mis = n_mis + 1;
    end
    if ((bus.rx_valid && prev_valid) || (bus.feedback_update && prev_upd) ||
        (bus.frame_error && prev_fe)) begin
      n_wide = n_wide + 1;
    end
    if (bus.feedback_stale && !prev_stale) rise_cyc = cyc;
    prev_valid = bus.rx_valid;
    prev_upd   = bus.feedback_update;
    prev_fe    = bus.frame_error;
    prev_stale = bus.feedback_stale;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    bus.rx = 1'b0;
    repeat (BitCycles) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (BitCycles) @(negedge clk);
    end
    bus.rx = stop_bit;
    repeat (BitCycles) @(negedge clk);
    bus.rx = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    bus.rx = 1'b1;
    rst    = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;

    // Idle after reset.
    repeat (100) @(negedge clk);
    check("rst_feedback", 32'(bus.feedback), 32'h00);
    check("rst_rx_byte", 32'(bus.rx_byte), 32'h00);
    check("rst_stale", 32'(bus.feedback_stale), 32'h1);
    check("rst_no_valid", n_valid, 0);
    check("rst_no_upd", n_upd, 0);
    check("rst_no_fe", n_fe, 0);

    // Feedback channel byte.
    send_frame(8'h45, 1'b1);
    check("fb45_rx_byte", 32'(bus.rx_byte), 32'h45);
    check("fb45_feedback", 32'(bus.feedback), 32'h45);
    check("fb45_valid_cnt", n_valid, 1);
    check("fb45_upd_cnt", n_upd, 1);
    check("fb45_stale", 32'(bus.feedback_stale), 32'h0);
    check("fb45_stale_at_upd", 32'(stale_at_upd), 32'h0);

    // Other channel: rx_byte only; staleness keeps running and rises 1000 cycles on.
    send_frame(8'h46, 1'b1);
    check("ch2_rx_byte", 32'(bus.rx_byte), 32'h46);
    check("ch2_feedback_held", 32'(bus.feedback), 32'h45);
    check("ch2_valid_cnt", n_valid, 2);
    check("ch2_upd_cnt", n_upd, 1);
    check("stale_high", 32'(bus.feedback_stale), 32'h1);
    check("stale_delay", rise_cyc - upd_cyc, 1000);

    // Stop bit low.
    send_frame(8'h45, 1'b0);
    check("fe_cnt", n_fe, 1);
    check("fe_valid_cnt", n_valid, 2);
    check("fe_rx_byte", 32'(bus.rx_byte), 32'h46);
    check("fe_feedback", 32'(bus.feedback), 32'h45);

    // Short low glitch on an idle line.
    bus.rx = 1'b0;
    repeat (3) @(negedge clk);
    bus.rx = 1'b1;
    repeat (BitCycles) @(negedge clk);
    check("glitch_valid_cnt", n_valid, 2);
    check("glitch_fe_cnt", n_fe, 1);
    send_frame(8'h81, 1'b1);
    check("post_glitch_rx_byte", 32'(bus.rx_byte), 32'h81);
    check("post_glitch_feedback", 32'(bus.feedback), 32'h81);
    check("post_glitch_upd_cnt", n_upd, 2);

    // Reset in the middle of data bit 4; bits 4..7 of 0xF1 are high so the tail looks idle.
    fork
      send_frame(8'hF1, 1'b1);
      begin
        repeat (BitCycles * 5 + BitCycles / 2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
    join
    check("midrst_valid_cnt", n_valid, 3);
    check("midrst_upd_cnt", n_upd, 2);
    check("midrst_fe_cnt", n_fe, 1);
    check("midrst_rx_byte", 32'(bus.rx_byte), 32'h00);
    check("midrst_feedback", 32'(bus.feedback), 32'h00);
    check("midrst_stale", 32'(bus.feedback_stale), 32'h1);

    send_frame(8'h05, 1'b1);
    check("fb05_rx_byte", 32'(bus.rx_byte), 32'h05);
    check("fb05_feedback", 32'(bus.feedback), 32'h05);
    check("fb05_upd_cnt", n_upd, 3);
    check("fb05_stale_at_upd", 32'(stale_at_upd), 32'h0);
    repeat (1100) @(negedge clk);
    check("fb05_stale_high", 32'(bus.feedback_stale), 32'h1);
    check("fb05_stale_delay", rise_cyc - upd_cyc, 1000);

    check("pulse_width", n_wide, 0);
    check("upd_without_valid", n_mis, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/feedback_receiver.md
Name: feedback_receiver

Overview:
- UART receive path that deserialises bytes arriving from the game side and keeps the latest feedback byte that the script and fixer logic consume.
- Counterpart of the command transmit path: commands go out as {payload[5:0], channel[1:0]}; feedback comes back in the same byte format.
- Sits between the board RX pin and the script engine. Provides a held feedback register, one-cycle update strobes, a framing-error flag and a staleness flag.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD, 9600: line rate. Format is 8N1, LSB first, idle high.
- OVERSAMPLE, 16: baud ticks per bit.
- STALE_CYCLES, 50_000_000: number of cycles without a feedback byte before feedback_stale asserts.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous reset, active-high.
- rx, input, 1: asynchronous serial input from the game.
- rx_byte, output, 8: last correctly framed byte on any channel.
- rx_valid, output, 1: one-cycle pulse when rx_byte updates.
- feedback, output, 8: last byte whose channel bits [1:0] equal `Receiver_Channel_Feedback. Held until the next such byte.
- feedback_update, output, 1: one-cycle pulse, coincident with rx_valid, when feedback updates.
- frame_error, output, 1: one-cycle pulse when the stop bit is sampled low.
- feedback_stale, output, 1: high once STALE_CYCLES elapse with no feedback_update.

Behaviour:
- Reset values: rx_byte=0, rx_valid=0, feedback=0, feedback_update=0, frame_error=0, feedback_stale=1, FSM=IDLE, all counters=0.
- Reset asserted mid-frame aborts the frame, and no strobe is produced for it.
- Synchroniser: two flops on rx, both reset to 1. All FSM logic uses the synchronised signal rx_s.
- Tick generator: DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer truncation (651 at defaults).
  - Counter runs 0..DIV-1 and emits a one-cycle tick at DIV-1, then wraps.
  - It runs freely in every state except IDLE, where it is held at 0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on rx_s==0, go to START and clear the tick and sample counters.
  - START: at tick count OVERSAMPLE/2-1 (the mid-bit point), re-sample rx_s.
    - If rx_s==1, it was a glitch: return to IDLE with no strobe.
    - Otherwise go to DATA with bit index 0 and the sample counter cleared.
  - DATA: every OVERSAMPLE ticks, sample rx_s into shift[bit_idx], LSB first. After bit 7, go to STOP.
  - STOP: after OVERSAMPLE ticks, sample rx_s.
    - If 1: rx_byte<=shift and rx_valid=1. If shift[1:0]==`Receiver_Channel_Feedback, also feedback<=shift and feedback_update=1.
    - If 0: frame_error=1 and no other register changes.
    - In both cases return to IDLE the next cycle. A low line re-arms START only after rx_s returns high, so a stuck-low line produces no repeated frames.
- Latency: strobes occur in the cycle after the mid-stop-bit sample, about 9.5 bit times after the falling edge of the start bit.
- Stale counter:
  - Cleared on feedback_update. feedback_stale clears in the same cycle.
  - Otherwise increments, saturating at STALE_CYCLES. feedback_stale=1 while count==STALE_CYCLES.
  - It must not wrap.
- Non-feedback channels update rx_byte only. The feedback register and the stale counter are untouched.
- Back-to-back frames: a start bit that begins immediately after the stop sample is accepted, because the IDLE transition happens within one cycle.

Decomposition:
- ConstValue.vh gains `Receiver_Channel_Feedback (2'b01) beside the existing `Receiver_Feedback_* bit indices. The consumers index feedback with those existing macros.
- One natural sub-module: uart_rx_core. It holds the synchroniser, tick generator and FSM, and outputs byte/valid/frame_error.
- feedback_receiver wraps uart_rx_core and adds channel filtering, the feedback hold register and the stale counter.

Test Plan:
- Reset, then idle line for 100 cycles: expect feedback=0x00, feedback_stale=1, and no strobes.
- Send 0x45 (channel 01) at 9600 baud: expect rx_valid and feedback_update pulse once, each exactly one cycle, with rx_byte=feedback=0x45 and feedback_stale=0.
- Send 0x46 (channel 10): expect rx_byte=0x46 and rx_valid pulse. feedback must stay 0x45 with no feedback_update.
- Send 0x45 with the stop bit forced low: expect frame_error pulse, no rx_valid, and rx_byte unchanged.
- 3-cycle low glitch on idle rx: expect the FSM back in IDLE within half a bit time, no strobes. Then send 0x81, received correctly.
- Assert rst at data bit 4 of a frame, then release: expect no strobe for that frame and all outputs at reset values. A following frame 0x05 is received correctly.
- Stale check with STALE_CYCLES=1000: feedback_stale rises exactly 1000 cycles after the last feedback_update and stays high. A new feedback byte clears it in the strobe cycle.
